// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : intersection_scheduler
//  Purpose  : Two-approach (main A, side B) traffic phase scheduler. Runs the
//             cycle RED_BA -> A_GREEN -> A_YELLOW -> RED_AB -> B_GREEN ->
//             B_YELLOW -> RED_BA. A rests in green until B has demand from a
//             vehicle or a pedestrian. Pedestrian requests are latched per
//             approach and served with a walk indication plus extended green.
//  Ports    : clk            - system clock, rising edge
//             reset_n        - asynchronous active-low reset
//             preempt        - (INTERSECTION_PREEMPT_EN only) preemption level
//             timer_config   - {MIN_GREEN_A, GREEN_B, YELLOW_T, ALL_RED_T}
//             ped_extension  - extra green cycles for a served pedestrian
//             car_b          - side-street vehicle detector (level)
//             ped_a / ped_b  - pedestrian requests (pulse or level)
//             light_a/_b     - heads, RED=100 YELLOW=010 GREEN=001
//             walk_a/_b      - walk indications
//             phase          - current state encoding (debug)
//  Options  : define INTERSECTION_PREEMPT_EN to add the preempt input and the
//             HOLD state (encoding 6). Otherwise encoding 6 is illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module intersection_scheduler #(
    parameter int TW = 6
) (
    input  logic            clk,
    input  logic            reset_n,
`ifdef INTERSECTION_PREEMPT_EN
    input  logic            preempt,
`endif
    input  logic [4*TW-1:0] timer_config,
    input  logic [TW-1:0]   ped_extension,
    input  logic            car_b,
    input  logic            ped_a,
    input  logic            ped_b,
    output logic [2:0]      light_a,
    output logic [2:0]      light_b,
    output logic            walk_a,
    output logic            walk_b,
    output logic [2:0]      phase
);

    typedef enum logic [2:0] {
        S_RED_BA   = 3'd0,
        S_A_GREEN  = 3'd1,
        S_A_YELLOW = 3'd2,
        S_RED_AB   = 3'd3,
        S_B_GREEN  = 3'd4,
        S_B_YELLOW = 3'd5,
        S_HOLD     = 3'd6
    } state_t;

    localparam logic [TW:0] c_ONE = {{TW{1'b0}}, 1'b1};

    // A state of duration D lasts max(D,1) cycles, so the counter loads D-1
    // with zero clamped to zero.
    function automatic logic [TW:0] f_load(input logic [TW:0] dur);
        return (dur == '0) ? '0 : dur - c_ONE;
    endfunction

    state_t      r_state;
    logic [TW:0] r_cnt;
    logic        r_pend_a;
    logic        r_pend_b;
    logic        r_srv_a;
    logic        r_srv_b;

    logic [TW:0] w_min_a;
    logic [TW:0] w_green_b;
    logic [TW:0] w_yellow;
    logic [TW:0] w_all_red;
    logic [TW:0] w_ext;
    logic [TW:0] w_ag_load;
    logic [TW:0] w_bg_load;
    logic        w_zero;
    logic        w_pre;
    logic        w_srv_a;
    logic        w_srv_b;
    logic        w_demand_b;
    logic        w_enter_a;
    logic        w_enter_b;

    // Fields are widened to TW+1 bits so green plus extension cannot overflow.
    assign w_min_a   = {1'b0, timer_config[4*TW-1:3*TW]};
    assign w_green_b = {1'b0, timer_config[3*TW-1:2*TW]};
    assign w_yellow  = {1'b0, timer_config[2*TW-1:TW]};
    assign w_all_red = {1'b0, timer_config[TW-1:0]};
    assign w_ext     = {1'b0, ped_extension};

`ifdef INTERSECTION_PREEMPT_EN
    assign w_pre = preempt;
`else
    assign w_pre = 1'b0;
`endif

    assign w_zero     = (r_cnt == '0);
    assign w_srv_a    = r_pend_a | ped_a;
    assign w_srv_b    = r_pend_b | ped_b;
    assign w_demand_b = car_b | r_pend_b | ped_b;
    assign w_ag_load  = f_load(w_min_a + (w_srv_a ? w_ext : '0));
    assign w_bg_load  = f_load(w_green_b + (w_srv_b ? w_ext : '0));

    // Green entry happens only from the matching all-red state at expiry and
    // never while preemption diverts the all-red state to HOLD.
    assign w_enter_a = (r_state == S_RED_BA) & w_zero & ~w_pre;
    assign w_enter_b = (r_state == S_RED_AB) & w_zero & ~w_pre;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_RED_BA;
            r_cnt    <= '0;
            r_pend_a <= 1'b0;
            r_pend_b <= 1'b0;
            r_srv_a  <= 1'b0;
            r_srv_b  <= 1'b0;
        end else begin
            // A request on the entry cycle is served and also stays pending.
            r_pend_a <= (r_pend_a & ~w_enter_a) | ped_a;
            r_pend_b <= (r_pend_b & ~w_enter_b) | ped_b;

            case (r_state)
                S_RED_BA: begin
                    if (w_pre) begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                    end else if (w_zero) begin
                        r_state <= S_A_GREEN;
                        r_cnt   <= w_ag_load;
                        r_srv_a <= w_srv_a;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                S_A_GREEN: begin
                    if (w_pre || (w_zero && w_demand_b)) begin
                        r_state <= S_A_YELLOW;
                        r_cnt   <= f_load(w_yellow);
                    end else if (!w_zero) begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                S_A_YELLOW: begin
                    if (w_zero) begin
                        r_state <= w_pre ? S_HOLD : S_RED_AB;
                        r_cnt   <= w_pre ? '0 : f_load(w_all_red);
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                S_RED_AB: begin
                    if (w_pre) begin
                        r_state <= S_HOLD;
                        r_cnt   <= '0;
                    end else if (w_zero) begin
                        r_state <= S_B_GREEN;
                        r_cnt   <= w_bg_load;
                        r_srv_b <= w_srv_b;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                S_B_GREEN: begin
                    if (w_pre || w_zero) begin
                        r_state <= S_B_YELLOW;
                        r_cnt   <= f_load(w_yellow);
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                S_B_YELLOW: begin
                    if (w_zero) begin
                        r_state <= w_pre ? S_HOLD : S_RED_BA;
                        r_cnt   <= w_pre ? '0 : f_load(w_all_red);
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
`ifdef INTERSECTION_PREEMPT_EN
                S_HOLD: begin
                    if (!w_pre) begin
                        r_state <= S_RED_BA;
                        r_cnt   <= f_load(w_all_red);
                    end
                end
`endif
                default: begin
                    // Unreachable encodings recover through a full clearance.
                    r_state <= S_RED_BA;
                    r_cnt   <= f_load(w_all_red);
                end
            endcase
        end
    end

    // Pure decode of the state registers; any non-A/B-active state is red.
    always_comb begin
        light_a = 3'b100;
        light_b = 3'b100;
        walk_a  = 1'b0;
        walk_b  = 1'b0;
        case (r_state)
            S_A_GREEN: begin
                light_a = 3'b001;
                walk_a  = r_srv_a;
            end
            S_A_YELLOW: light_a = 3'b010;
            S_B_GREEN: begin
                light_b = 3'b001;
                walk_b  = r_srv_b;
            end
            S_B_YELLOW: light_b = 3'b010;
            default: ;
        endcase
    end

    assign phase = r_state;

endmodule
`default_nettype wire
